// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and widths for the RV64 writeback stage
package wb_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_t;

    // One buffered result; data is already aligned/extended when stored
    typedef struct packed {
        logic            we;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } wb_entry_t;

endpackage

// File: rtl/ld_align.sv
// rtl/ld_align.sv - combinational load-data byte-lane shift and sign/zero extension
module ld_align
    import wb_pkg::*;
(
    input  logic            is_load,
    input  ld_size_t        size,
    input  logic            is_unsigned,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    // Move the addressed byte lane to bit 0, then extend to the access width;
    // misaligned offsets simply shift whatever bytes remain, no trap
    always_comb begin
        shifted = data >> {offset, 3'b000};
        result  = data;
        if (is_load) begin
            case (size)
                LD_B: result = is_unsigned ? {56'b0, shifted[7:0]}
                                           : {{56{shifted[7]}}, shifted[7:0]};
                LD_H: result = is_unsigned ? {48'b0, shifted[15:0]}
                                           : {{48{shifted[15]}}, shifted[15:0]};
                LD_W: result = is_unsigned ? {32'b0, shifted[31:0]}
                                           : {{32{shifted[31]}}, shifted[31:0]};
                LD_D: result = shifted;
            endcase
        end
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage with skid FIFO and retire counter; WB_BYPASS_EN adds operand forwarding ports
module wb_stage
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_we,
    input  logic [4:0]      in_rd_addr,
    input  logic            in_is_load,
    input  logic [1:0]      in_ld_size,
    input  logic            in_ld_unsigned,
    input  logic [2:0]      in_ld_offset,
    input  logic [XLEN-1:0] in_data,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_hold,
    input  logic            flush,
`ifdef WB_BYPASS_EN
    input  logic [4:0]      byp_rs1addr,
    input  logic [4:0]      byp_rs2addr,
    output logic            byp_rs1_hit,
    output logic            byp_rs2_hit,
    output logic [XLEN-1:0] byp_rs1_data,
    output logic [XLEN-1:0] byp_rs2_data,
`endif
    output logic            wb_valid,
    output logic            RFwe,
    output logic [4:0]      rdaddr,
    output logic [XLEN-1:0] rd,
    output logic [XLEN-1:0] retire_pc,
    output logic [XLEN-1:0] instret
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CNT_W-1:0] count;

    logic [XLEN-1:0] aligned;
    wb_entry_t       in_entry;
    wb_entry_t       out_src;
    logic            fifo_empty;
    logic            accept;
    logic            pop;
    logic            push;
    logic            direct;

    ld_align u_ld_align (
        .is_load     (in_is_load),
        .size        (ld_size_t'(in_ld_size)),
        .is_unsigned (in_ld_unsigned),
        .offset      (in_ld_offset),
        .data        (in_data),
        .result      (aligned)
    );

    // Handshake decode: an empty FIFO with no stall lets the new result skip the buffer
    always_comb begin
        in_entry   = '{we: in_we, rd_addr: in_rd_addr, data: aligned, pc: in_pc};
        fifo_empty = (count == '0);
        in_ready   = (count != CNT_FULL);
        accept     = in_valid && in_ready && !flush;
        pop        = !wb_hold && !fifo_empty;
        direct     = accept && !wb_hold && fifo_empty;
        push       = accept && !direct;
        out_src    = pop ? mem[rd_ptr] : in_entry;
    end

    // FIFO storage; contents are only meaningful between rd_ptr and wr_ptr
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered regfile write port and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            RFwe      <= 1'b0;
            rdaddr    <= '0;
            rd        <= '0;
            retire_pc <= '0;
            instret   <= '0;
        end else begin
            instret <= instret + {{(XLEN-1){1'b0}}, wb_valid};
            if (flush || wb_hold || !(pop || direct)) begin
                wb_valid <= 1'b0;
                RFwe     <= 1'b0;
            end else begin
                wb_valid  <= 1'b1;
                RFwe      <= out_src.we && (out_src.rd_addr != 5'd0);
                rdaddr    <= out_src.rd_addr;
                rd        <= out_src.data;
                retire_pc <= out_src.pc;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Youngest pending write to addr: output register is oldest, FIFO tail is youngest
    function automatic logic [XLEN:0] byp_lookup(input logic [4:0] addr);
        logic [XLEN:0] res;
        logic [PW-1:0] idx;
        res = '0;
        if (addr != 5'd0) begin
            if (wb_valid && RFwe && rdaddr == addr) begin
                res = {1'b1, rd};
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PW'(i);
                if (CNT_W'(i) < count && mem[idx].we && mem[idx].rd_addr == addr) begin
                    res = {1'b1, mem[idx].data};
                end
            end
        end
        return res;
    endfunction

    // Operand forwarding from results not yet written to the regfile
    always_comb begin
        {byp_rs1_hit, byp_rs1_data} = byp_lookup(byp_rs1addr);
        {byp_rs2_hit, byp_rs2_data} = byp_lookup(byp_rs2addr);
    end
`endif

endmodule
